// File: rtl/ahb_arb_pkg.sv
// Shared encodings and helpers for the AHB round-robin arbiter.
// The macro AHB_ARB_BURST_HOLD_EN turns on the optional burst-hold logic.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam int BEAT_CNT_W = 4;

    // Number of beats in a fixed-length burst; SINGLE and undefined-length INCR report 1.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        logic [4:0] len;
        case (hburst)
            3'd2, 3'd3: len = 5'd4;
            3'd4, 3'd5: len = 5'd8;
            3'd6, 3'd7: len = 5'd16;
            default:    len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr_i (wrapping),
// with ptr_i itself scanned last.
module ahb_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             hit;

    // Scan offsets 1..N from the pointer and keep the first hit.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        hit      = 1'b0;
        for (int off = 1; off <= N; off++) begin
            cand     = (int'(ptr_i) + off) % N;
            cand_idx = IDX_W'(cand);
            hit      = !valid_o && req_i[cand_idx];
            idx_o    = hit ? cand_idx : idx_o;
            valid_o  = valid_o | hit;
        end
        gnt_o = valid_o ? (ONE_HOT0 << idx_o) : '0;
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter with HLOCK hold; optional burst hold when
// AHB_ARB_BURST_HOLD_EN is defined.
module ahb_rr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int MASTER_BITS = 4,
    parameter int DEF_MASTER  = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MASTER_BITS-1:0] HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [MASTER_BITS-1:0] DEF_IDX = MASTER_BITS'(DEF_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    // The rr pointer always names the current grant holder, so it doubles as the owner index.
    logic [MASTER_BITS-1:0] ptr_q, ptr_d;
    logic [MASTER_BITS-1:0] master_q, master_d;
    logic                   mlock_q, mlock_d;

    logic [NUM_MASTERS-1:0] pick_gnt_s;
    logic [MASTER_BITS-1:0] pick_idx_s;
    logic                   pick_valid_s;
    logic                   lock_hold_s;
    logic                   burst_hold_s;

    ahb_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (MASTER_BITS)
    ) u_pick (
        .req_i   (HBUSREQ),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    assign lock_hold_s = HLOCK[ptr_q] & HBUSREQ[ptr_q];

`ifdef AHB_ARB_BURST_HOLD_EN
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [4:0]            blen_s;

    assign blen_s = burst_len(HBURST);

    // Freeze from the NONSEQ of a fixed burst until the last beat's address (counter==1);
    // an IDLE ends the burst early and releases the grant in that same cycle.
    assign burst_hold_s = ((HTRANS == HTRANS_NONSEQ) && (blen_s > 5'd1)) ||
                          (((HTRANS == HTRANS_SEQ) || (HTRANS == HTRANS_BUSY)) &&
                           (beat_cnt_q > 4'd1));

    // Beat counter next-state: load on burst start, count SEQ beats, clear on IDLE.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (HREADY) begin
            case (HTRANS)
                HTRANS_NONSEQ: beat_cnt_d = (blen_s > 5'd1) ? BEAT_CNT_W'(blen_s - 5'd1) : beat_cnt_q;
                HTRANS_SEQ:    beat_cnt_d = (beat_cnt_q != 4'd0) ? (beat_cnt_q - 4'd1) : 4'd0;
                HTRANS_IDLE:   beat_cnt_d = 4'd0;
                default:       beat_cnt_d = beat_cnt_q;
            endcase
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Beat counter register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beat_cnt_q <= 4'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    logic unused_s;
    assign unused_s     = ^{HTRANS, HBURST};
    assign burst_hold_s = 1'b0;
`endif

    // Arbitration next-state; everything holds while HREADY is low.
    always_comb begin
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        master_d = master_q;
        mlock_d  = mlock_q;
        if (HREADY) begin
            master_d = ptr_q;
            mlock_d  = HLOCK[ptr_q];
            if (lock_hold_s || burst_hold_s) begin
                grant_d = grant_q;
                ptr_d   = ptr_q;
            end else if (pick_valid_s) begin
                grant_d = pick_gnt_s;
                ptr_d   = pick_idx_s;
            end else begin
                grant_d = DEF_GNT;
                ptr_d   = DEF_IDX;
            end
        end else begin
            grant_d = grant_q;
            ptr_d   = ptr_q;
        end
    end

    // Grant, pointer, master and lock registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q  <= DEF_GNT;
            ptr_q    <= DEF_IDX;
            master_q <= DEF_IDX;
            mlock_q  <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            master_q <= master_d;
            mlock_q  <= mlock_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scoreboard bench for ahb_rr_arbiter: directed vectors push hand-computed
// expectations; a monitor pops and compares one entry after every clock edge.
module tb_ahb_rr_arbiter;
    import ahb_arb_pkg::*;

`ifdef AHB_ARB_BURST_HOLD_EN
    localparam bit BH = 1'b1;
`else
    localparam bit BH = 1'b0;
`endif

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [2:0] HBUSREQ;
    logic [2:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [2:0] HGRANT;
    logic [3:0] HMASTER;
    logic       HMASTLOCK;

    typedef struct packed {
        logic [2:0] gnt;
        logic [3:0] mst;
        logic       lck;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    ahb_rr_arbiter #(
        .NUM_MASTERS (3),
        .MASTER_BITS (4),
        .DEF_MASTER  (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input exp_t e);
        n_checks++;
        if (HGRANT !== e.gnt || HMASTER !== e.mst || HMASTLOCK !== e.lck) begin
            n_fail++;
            $display("FAIL %s: got HGRANT=%b HMASTER=%0d HMASTLOCK=%b, expected HGRANT=%b HMASTER=%0d HMASTLOCK=%b",
                     tag, HGRANT, HMASTER, HMASTLOCK, e.gnt, e.mst, e.lck);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what must appear after the next rising edge.
    task automatic step(input logic [2:0] req, input logic [2:0] lock, input logic rdy,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic [2:0] eg, input logic [3:0] em, input logic el,
                        input string tag);
        @(negedge HCLK);
        HBUSREQ = req;
        HLOCK   = lock;
        HREADY  = rdy;
        HTRANS  = tr;
        HBURST  = bu;
        exp_q.push_back(exp_t'({eg, em, el}));
        tag_q.push_back(tag);
    endtask

    always begin
        @(posedge HCLK);
        #1;
        if (exp_q.size() != 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        HBUSREQ = 3'b000;
        HLOCK   = 3'b000;
        HREADY  = 1'b1;
        HTRANS  = HTRANS_IDLE;
        HBURST  = HBURST_SINGLE;
        repeat (2) @(negedge HCLK);
        check("reset_values", exp_t'({3'b001, 4'd0, 1'b0}));
        HRESETn = 1'b1;

        // 1: idle bus parks on the default master
        for (int i = 0; i < 20; i++)
            step(3'b000, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b001, 4'd0, 1'b0, "t1_idle_hold");

        // 2: masters 1 and 2 alternate, HMASTER lags one edge
        step(3'b110, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b010, 4'd0, 1'b0, "t2_rr_e1");
        step(3'b110, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b100, 4'd1, 1'b0, "t2_rr_e2");
        step(3'b110, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b010, 4'd2, 1'b0, "t2_rr_e3");
        step(3'b110, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b100, 4'd1, 1'b0, "t2_rr_e4");

        // 3: locked owner 2 keeps the bus, then releases to master 0
        for (int i = 0; i < 5; i++)
            step(3'b111, 3'b100, 1'b1, HTRANS_IDLE, 3'd0, 3'b100, 4'd2, 1'b1, "t3_lock_hold");
        step(3'b111, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b001, 4'd2, 1'b0, "t3_lock_release");
        step(3'b000, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b001, 4'd0, 1'b0, "t3_park");

        // 4: HREADY low freezes everything despite request/lock activity
        step(3'b010, 3'b001, 1'b0, HTRANS_IDLE, 3'd0, 3'b001, 4'd0, 1'b0, "t4_wait1");
        step(3'b100, 3'b001, 1'b0, HTRANS_IDLE, 3'd0, 3'b001, 4'd0, 1'b0, "t4_wait2");
        step(3'b110, 3'b001, 1'b0, HTRANS_IDLE, 3'd0, 3'b001, 4'd0, 1'b0, "t4_wait3");
        step(3'b011, 3'b001, 1'b0, HTRANS_IDLE, 3'd0, 3'b001, 4'd0, 1'b0, "t4_wait4");
        step(3'b100, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b100, 4'd0, 1'b0, "t4_ready_update");
        step(3'b000, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b001, 4'd2, 1'b0, "t4_park");

        // 5: master 1 INCR4 burst with master 2 waiting
        step(3'b010, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b010, 4'd0, 1'b0, "t5_grant_m1");
        step(3'b010, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b010, 4'd1, 1'b0, "t5_m1_owns");
        step(3'b110, 3'b000, 1'b1, HTRANS_NONSEQ, HBURST_INCR4,
             BH ? 3'b010 : 3'b100, 4'd1, 1'b0, "t5_beat1");
        step(3'b110, 3'b000, 1'b1, HTRANS_SEQ, HBURST_INCR4,
             BH ? 3'b010 : 3'b010, BH ? 4'd1 : 4'd2, 1'b0, "t5_beat2");
        step(3'b110, 3'b000, 1'b1, HTRANS_SEQ, HBURST_INCR4,
             BH ? 3'b010 : 3'b100, 4'd1, 1'b0, "t5_beat3");
        step(3'b110, 3'b000, 1'b1, HTRANS_SEQ, HBURST_INCR4,
             BH ? 3'b100 : 3'b010, BH ? 4'd1 : 4'd2, 1'b0, "t5_beat4");
        step(3'b100, 3'b000, 1'b1, HTRANS_IDLE, 3'd0,
             3'b100, BH ? 4'd2 : 4'd1, 1'b0, "t5_after_burst");
        // 5b: same burst terminated by IDLE after beat 2
        step(3'b010, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b010, 4'd2, 1'b0, "t5b_grant_m1");
        step(3'b010, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b010, 4'd1, 1'b0, "t5b_m1_owns");
        step(3'b110, 3'b000, 1'b1, HTRANS_NONSEQ, HBURST_INCR4,
             BH ? 3'b010 : 3'b100, 4'd1, 1'b0, "t5b_beat1");
        step(3'b110, 3'b000, 1'b1, HTRANS_SEQ, HBURST_INCR4,
             3'b010, BH ? 4'd1 : 4'd2, 1'b0, "t5b_beat2");
        step(3'b110, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b100, 4'd1, 1'b0, "t5b_idle_release");

        // 6: asynchronous reset in the middle of a locked burst owned by master 2
        step(3'b100, 3'b100, 1'b1, HTRANS_NONSEQ, HBURST_INCR8, 3'b100, 4'd2, 1'b1, "t6_burst_start");
        step(3'b100, 3'b100, 1'b1, HTRANS_SEQ, HBURST_INCR8, 3'b100, 4'd2, 1'b1, "t6_burst_seq");
        @(posedge HCLK);
        #3;
        HRESETn = 1'b0;
        #1;
        check("t6_async_reset", exp_t'({3'b001, 4'd0, 1'b0}));
        @(negedge HCLK);
        HBUSREQ = 3'b000;
        HLOCK   = 3'b000;
        HTRANS  = HTRANS_IDLE;
        HBURST  = HBURST_SINGLE;
        @(negedge HCLK);
        HRESETn = 1'b1;
        step(3'b000, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b001, 4'd0, 1'b0, "t6_after_reset");
        step(3'b100, 3'b000, 1'b1, HTRANS_IDLE, 3'd0, 3'b100, 4'd0, 1'b0, "t6_regrant");

        @(posedge HCLK);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
